// File: rtl/lcd_write_ci.sv
// Nios II multi-cycle custom instruction: writes one command/character byte to an HD44780-class LCD.
// Define LCD_NIBBLE_MODE_EN for the 4-bit bus variant (two E strobes per byte on lcd_data[7:4]).
`timescale 1ns/1ps
// state | meaning
// IDLE  | waiting for start; byte/RS latched on accept
// SETUP | RS/DATA stable, E low (address setup)
// PULSE | E high
// HOLD  | E low, RS/DATA held
// WAIT  | LCD execution time (long for clear/home)
// DONE  | one-cycle done pulse, result updated
module lcd_write_ci #(
   parameter int unsigned T_SETUP_CYC = 4,
   parameter int unsigned T_EN_CYC    = 25,
   parameter int unsigned T_HOLD_CYC  = 2,
   parameter int unsigned T_CMD_CYC   = 2500,
   parameter int unsigned T_CLR_CYC   = 82000,
   parameter int          CNT_W       = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result,
   output logic        done,
   output logic        lcd_enable,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic [7:0]  lcd_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_PULSE = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(T_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_TC    = CNT_W'(T_EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(T_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_TC   = CNT_W'(T_CMD_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_TC   = CNT_W'(T_CLR_CYC - 1);

`ifdef LCD_NIBBLE_MODE_EN
   localparam logic NIB_FLAG = 1'b1;
`else
   localparam logic NIB_FLAG = 1'b0;
`endif

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             rs_q, rs_d;
   logic             long_q, long_d;
   logic [7:0]       data_q, data_d;
   logic             lrs_q, lrs_d;
   logic             e_q, e_d;
   logic             done_q, done_d;
   logic [31:0]      result_q, result_d;
`ifdef LCD_NIBBLE_MODE_EN
   logic             nib_q, nib_d;
`endif

   logic unused_bits;
   assign unused_bits = ^{dataa[31:8], datab[31:1]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      byte_d   = byte_q;
      rs_d     = rs_q;
      long_d   = long_q;
      data_d   = data_q;
      lrs_d    = lrs_q;
      e_d      = e_q;
      done_d   = 1'b0;
      result_d = result_q;
`ifdef LCD_NIBBLE_MODE_EN
      nib_d    = nib_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               byte_d  = dataa[7:0];
               rs_d    = datab[0];
               lrs_d   = datab[0];
               // Clear Display (01) and Return Home (02/03) need the long execution wait
               long_d  = ~datab[0] & ((dataa[7:1] == 7'b0000001) | (dataa[7:0] == 8'h01));
`ifdef LCD_NIBBLE_MODE_EN
               data_d  = {dataa[7:4], 4'b0000};
               nib_d   = 1'b0;
`else
               data_d  = dataa[7:0];
`endif
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_TC) begin
               state_d = S_PULSE;
               cnt_d   = '0;
               e_d     = 1'b1;
            end
         end
         S_PULSE: begin
            if (cnt_q == EN_TC) begin
               state_d = S_HOLD;
               cnt_d   = '0;
               e_d     = 1'b0;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_TC) begin
               cnt_d   = '0;
               state_d = S_WAIT;
`ifdef LCD_NIBBLE_MODE_EN
               if (!nib_q) begin
                  nib_d   = 1'b1;
                  data_d  = {byte_q[3:0], 4'b0000};
                  state_d = S_SETUP;
               end
`endif
            end
         end
         S_WAIT: begin
            if (cnt_q == (long_q ? CLR_TC : CMD_TC)) begin
               state_d  = S_DONE;
               cnt_d    = '0;
               done_d   = 1'b1;
               result_d = {1'b1, NIB_FLAG, 21'b0, rs_q, byte_q};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            e_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         byte_q   <= 8'h00;
         rs_q     <= 1'b0;
         long_q   <= 1'b0;
         data_q   <= 8'h00;
         lrs_q    <= 1'b0;
         e_q      <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'h0;
`ifdef LCD_NIBBLE_MODE_EN
         nib_q    <= 1'b0;
`endif
      end else if (clk_en) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         byte_q   <= byte_d;
         rs_q     <= rs_d;
         long_q   <= long_d;
         data_q   <= data_d;
         lrs_q    <= lrs_d;
         e_q      <= e_d;
         done_q   <= done_d;
         result_q <= result_d;
`ifdef LCD_NIBBLE_MODE_EN
         nib_q    <= nib_d;
`endif
      end
   end

   assign result     = result_q;
   assign done       = done_q;
   assign lcd_enable = e_q;
   assign lcd_rs     = lrs_q;
   assign lcd_rw     = 1'b0;
   assign lcd_data   = data_q;

endmodule

// File: tb/tb_lcd_write_ci.sv
// Self-checking bench for lcd_write_ci: vector table of writes, scoreboard of expected completions,
// plus hand-written sequences for clk_en-gated start and mid-operation reset.
`timescale 1ns/1ps
module tb_lcd_write_ci;
   localparam int TS = 2, TE = 3, TH = 1, TC = 10, TL = 40;
   localparam int LAT_N = TS + TE + TH + TC + 1;
   localparam int LAT_L = TS + TE + TH + TL + 1;
   localparam int NV = 9;

   logic        clk = 1'b0;
   logic        reset, clk_en, start;
   logic [31:0] dataa, datab, result;
   logic        done, lcd_enable, lcd_rs, lcd_rw;
   logic [7:0]  lcd_data;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_lat;
      int          frz_at;
      int          frz_len;
      bit          restart;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   vec_t vecs[NV];
   exp_t sb[$];

   always #5 clk = ~clk;

   lcd_write_ci #(
      .T_SETUP_CYC(TS), .T_EN_CYC(TE), .T_HOLD_CYC(TH),
      .T_CMD_CYC(TC), .T_CLR_CYC(TL), .CNT_W(24)
   ) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
      .dataa(dataa), .datab(datab), .result(result), .done(done),
      .lcd_enable(lcd_enable), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Entered #1 after a rising edge; the next edge is cycle 1 (the accepting edge).
   task automatic run_xfer(input vec_t v, input string tag);
      int   done_cyc, n_done, e_first, e_last, e_cnt, data_bad;
      exp_t e;
      sb.push_back('{v.exp_res, v.exp_lat});
      dataa = v.a; datab = v.b; start = 1'b1; clk_en = 1'b1;
      done_cyc = -1; n_done = 0; e_first = -1; e_last = -1; e_cnt = 0; data_bad = 0;
      for (int c = 1; c <= 120; c++) begin
         @(posedge clk); #1;
         start  = v.restart && (c == 4 || c == 17);
         dataa  = $urandom;
         datab  = $urandom;
         clk_en = !(v.frz_len > 0 && c >= v.frz_at && c < v.frz_at + v.frz_len);
         if (lcd_enable) begin
            e_cnt++;
            if (e_first < 0) e_first = c;
            e_last = c;
         end
         if (lcd_data !== v.a[7:0] || lcd_rs !== v.b[0] || lcd_rw !== 1'b0) data_bad++;
         if (done) begin
            n_done++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk({tag, "_result"}, result, e.res);
               chk({tag, "_latency"}, c, e.lat);
               done_cyc = c;
            end
         end
         if (done_cyc > 0 && c == done_cyc + 1) chk({tag, "_done_drop"}, {31'b0, done}, 32'h0);
         if (done_cyc > 0 && c == done_cyc + 4) break;
      end
      start = 1'b0; clk_en = 1'b1;
      chk({tag, "_done_count"}, n_done, 1);
      chk({tag, "_e_first"}, e_first, TS + 1);
      chk({tag, "_e_last"}, e_last, TS + TE + v.frz_len);
      chk({tag, "_e_cycles"}, e_cnt, TE + v.frz_len);
      chk({tag, "_bus_stable"}, data_bad, 0);
      chk({tag, "_result_hold"}, result, v.exp_res);
      sb.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      vecs[0] = '{32'h0000_0041, 32'h1,         32'h8000_0141, LAT_N, 0, 0, 1'b0};
      vecs[1] = '{32'h0000_0001, 32'h0,         32'h8000_0001, LAT_L, 0, 0, 1'b0};
      vecs[2] = '{32'h0000_0002, 32'h0,         32'h8000_0002, LAT_L, 0, 0, 1'b0};
      vecs[3] = '{32'h0000_0003, 32'h0,         32'h8000_0003, LAT_L, 0, 0, 1'b0};
      vecs[4] = '{32'h0000_0001, 32'h1,         32'h8000_0101, LAT_N, 0, 0, 1'b0};
      vecs[5] = '{32'h0000_0041, 32'h1,         32'h8000_0141, LAT_N, 0, 0, 1'b1};
      vecs[6] = '{32'h0000_0041, 32'h1,         32'h8000_0141, LAT_N + 5, 3, 5, 1'b0};
      vecs[7] = '{32'h0000_0004, 32'h0,         32'h8000_0004, LAT_N, 0, 0, 1'b0};
      vecs[8] = '{32'hDEAD_BE80, 32'hFFFF_FFFE, 32'h8000_0080, LAT_N, 0, 0, 1'b0};

      reset = 1'b0; start = 1'b0; clk_en = 1'b1; dataa = '0; datab = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", {31'b0, lcd_enable}, 32'h0);
      chk("rst_rs", {31'b0, lcd_rs}, 32'h0);
      chk("rst_rw", {31'b0, lcd_rw}, 32'h0);
      chk("rst_data", {24'b0, lcd_data}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_result", result, 32'h0);
      reset = 1'b1;
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (lcd_enable || done) bad++;
      end
      chk("idle_quiet", bad, 0);

      for (int i = 0; i < NV; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

      // start while clk_en is low must not be accepted
      start = 1'b1; clk_en = 1'b0; dataa = 32'h55; datab = 32'h1;
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b0; clk_en = 1'b1; dataa = 32'h0; datab = 32'h0;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (lcd_enable || done || lcd_data !== vecs[NV-1].a[7:0] || lcd_rs !== vecs[NV-1].b[0]) bad++;
      end
      chk("gated_start_ignored", bad, 0);

      // reset during the E pulse aborts without a done
      dataa = 32'h41; datab = 32'h1; start = 1'b1; clk_en = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("abort_e_before", {31'b0, lcd_enable}, 32'h1);
      reset = 1'b0;
      #1;
      chk("abort_e_async", {31'b0, lcd_enable}, 32'h0);
      chk("abort_result_cleared", result, 32'h0);
      bad = 0;
      repeat (3) begin @(posedge clk); #1; if (done || lcd_enable) bad++; end
      reset = 1'b1;
      repeat (25) begin @(posedge clk); #1; if (done || lcd_enable) bad++; end
      chk("abort_no_done", bad, 0);
      run_xfer(vecs[0], "post_abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
